// File: rtl/nonce_pkg.sv
// Shared types and range helpers for the nonce dispatcher.
// The lane ranges are computed here so the top and the bench agree on one definition.
package nonce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [63:0] span(input int ncore, input int w);
        logic [64:0] full;
        full = 65'd1 << w;
        return 64'(full / 65'(ncore));
    endfunction

    function automatic logic [63:0] range_start(input int i, input int ncore, input int w);
        return 64'(i) * span(ncore, w);
    endfunction

    // The last lane absorbs the remainder of the nonce space.
    function automatic logic [63:0] range_end(input int i, input int ncore, input int w);
        logic [64:0] full;
        full = 65'd1 << w;
        if (i == ncore - 1)
            return 64'(full - 65'd1);
        else
            return 64'(i + 1) * span(ncore, w) - 64'd1;
    endfunction

endpackage

// File: rtl/nonce_dispatcher_lane.sv
// One lane's nonce counter: reloads to its range start and stops at its range end.
// Reaching the end value does not exhaust the lane; the next advance request does.
module nonce_lane #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load,
    input  logic               adv,
    input  logic [NONCE_W-1:0] start_val,
    input  logic [NONCE_W-1:0] end_val,
    output logic [NONCE_W-1:0] nonce,
    output logic               exhausted
);

    always_ff @(posedge clk) begin
        if (!n_rst || load) begin
            nonce     <= start_val;
            exhausted <= 1'b0;
        end else if (adv && !exhausted) begin
            if (nonce == end_val)
                exhausted <= 1'b1;
            else
                nonce <= nonce + 1'b1;
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Multi-lane nonce dispatcher: per-core nonce ranges, run control FSM and golden-nonce capture.
// Optional hash counter is built only when NONCE_STATS_EN is defined.
//
// state   | meaning
// IDLE    | lanes hold, waiting for start
// RUN     | lanes advance on their last-round strobe, finds are captured
// HOLD    | a find stopped the search; waiting for host ack
// DONE    | every lane exhausted its range without a stopping find
module nonce_dispatcher
    import nonce_pkg::*;
#(
    parameter int NCORE         = 4,
    parameter int NONCE_W       = 32,
    parameter int CYC_W         = 6,
    parameter int ROUND_LAST    = 63,
    parameter bit STOP_ON_FOUND = 1'b1,
    localparam int CORE_W       = $clog2(NCORE) + 1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NCORE*CYC_W-1:0]   cycle,
    input  logic [NCORE-1:0]         core_found,
    input  logic                     found_ack,
    output logic [NCORE*NONCE_W-1:0] nonce,
    output logic [NCORE-1:0]         exhausted,
    output logic                     busy,
    output logic                     done,
    output logic                     found_valid,
    output logic [NONCE_W-1:0]       found_nonce,
    output logic [CORE_W-1:0]        found_core,
    output logic                     found_ovr,
    output logic [63:0]              hash_count
);

    state_t state, state_nxt;
    logic               run_go;
    logic [NCORE-1:0]   adv;
    logic [NCORE-1:0]   hit;
    logic [NONCE_W-1:0] lane_nonce [NCORE];
    logic [CORE_W-1:0]  win_idx;
    logic [NONCE_W-1:0] win_nonce;
    logic               capture;
    logic               multi_hit;
    logic               ovr_set;

    // start overrides any same-cycle advance or find
    assign run_go = (state == ST_RUN) && !start;
    assign hit    = run_go ? core_found : '0;

    for (genvar g = 0; g < NCORE; g++) begin : g_lane
        localparam logic [NONCE_W-1:0] LO = NONCE_W'(range_start(g, NCORE, NONCE_W));
        localparam logic [NONCE_W-1:0] HI = NONCE_W'(range_end(g, NCORE, NONCE_W));

        assign adv[g] = run_go && (cycle[g*CYC_W +: CYC_W] == CYC_W'(ROUND_LAST)) && !exhausted[g];

        nonce_lane #(.NONCE_W(NONCE_W)) u_lane (
            .clk       (clk),
            .n_rst     (n_rst),
            .load      (start),
            .adv       (adv[g]),
            .start_val (LO),
            .end_val   (HI),
            .nonce     (lane_nonce[g]),
            .exhausted (exhausted[g])
        );

        assign nonce[g*NONCE_W +: NONCE_W] = lane_nonce[g];
    end

    // Descending scan so the lowest reporting lane is the one left standing.
    always_comb begin
        win_idx   = '0;
        win_nonce = '0;
        for (int i = NCORE - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_idx   = CORE_W'(i);
                win_nonce = lane_nonce[i];
            end
        end
    end

    assign multi_hit = (hit & (hit - NCORE'(1))) != '0;
    assign capture   = (|hit) && !found_valid;
    assign ovr_set   = (|hit) && (found_valid || multi_hit);

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_RUN: begin
                    if (capture && STOP_ON_FOUND)
                        state_nxt = ST_HOLD;
                    else if (&exhausted)
                        state_nxt = ST_DONE;
                end
                ST_HOLD: begin
                    if (found_ack)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            found_valid <= 1'b0;
            found_nonce <= '0;
            found_core  <= '0;
            found_ovr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                found_valid <= 1'b0;
                found_ovr   <= 1'b0;
            end else begin
                if (capture) begin
                    found_valid <= 1'b1;
                    found_nonce <= win_nonce;
                    found_core  <= win_idx;
                end else if (found_ack) begin
                    found_valid <= 1'b0;
                end
                if (ovr_set)
                    found_ovr <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

`ifdef NONCE_STATS_EN
    localparam int ADD_W = $clog2(NCORE + 1);
    logic [ADD_W-1:0] adv_cnt;
    logic [64:0]      hc_sum;

    always_comb begin
        adv_cnt = '0;
        for (int i = 0; i < NCORE; i++)
            adv_cnt = adv_cnt + ADD_W'(adv[i]);
    end

    assign hc_sum = {1'b0, hash_count} + 65'(adv_cnt);

    always_ff @(posedge clk) begin
        if (!n_rst)
            hash_count <= '0;
        else
            hash_count <= hc_sum[64] ? '1 : hc_sum[63:0];
    end
`else
    assign hash_count = '0;
`endif

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model of the lanes and capture.
module tb_nonce_dispatcher;

    localparam int NC   = 4;
    localparam int W    = 8;
    localparam int CW   = 6;
    localparam int LAST = 63;
    localparam int CRW  = $clog2(NC) + 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            found_ack = 1'b0;
    logic [NC*CW-1:0] cycle = '0;
    logic [NC-1:0]   core_found = '0;
    logic [NC*W-1:0] nonce;
    logic [NC-1:0]   exhausted;
    logic            busy, done, found_valid, found_ovr;
    logic [W-1:0]    found_nonce;
    logic [CRW-1:0]  found_core;
    logic [63:0]     hash_count;

    // three-lane instance for the uneven split
    logic            start3 = 1'b0;
    logic [3*CW-1:0] cycle3 = '0;
    logic [3*W-1:0]  nonce3;
    logic [2:0]      exhausted3;
    logic            busy3, done3, fv3, ovr3;
    logic [W-1:0]    fn3;
    logic [2:0]      fc3;
    logic [63:0]     hc3;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    nonce_dispatcher #(.NCORE(NC), .NONCE_W(W), .CYC_W(CW), .ROUND_LAST(LAST), .STOP_ON_FOUND(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .cycle(cycle),
        .core_found(core_found), .found_ack(found_ack), .nonce(nonce), .exhausted(exhausted),
        .busy(busy), .done(done), .found_valid(found_valid), .found_nonce(found_nonce),
        .found_core(found_core), .found_ovr(found_ovr), .hash_count(hash_count)
    );

    nonce_dispatcher #(.NCORE(3), .NONCE_W(W), .CYC_W(CW), .ROUND_LAST(LAST), .STOP_ON_FOUND(1'b1)) dut3 (
        .clk(clk), .n_rst(n_rst), .start(start3), .abort(1'b0), .cycle(cycle3),
        .core_found(3'b000), .found_ack(1'b0), .nonce(nonce3), .exhausted(exhausted3),
        .busy(busy3), .done(done3), .found_valid(fv3), .found_nonce(fn3),
        .found_core(fc3), .found_ovr(ovr3), .hash_count(hc3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned     m_n [NC];
    bit              m_x [NC];
    int              m_st;
    bit              m_fv;
    int unsigned     m_fn;
    int              m_fc;
    bit              m_ovr;
    longint unsigned m_hc;

    function automatic int unsigned lo_of(int i);
        return ((1 << W) / NC) * i;
    endfunction

    function automatic int unsigned hi_of(int i);
        return (i == NC - 1) ? (1 << W) - 1 : lo_of(i + 1) - 1;
    endfunction

    always @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NC; i++) begin m_n[i] = lo_of(i); m_x[i] = 0; end
            m_st = M_IDLE; m_fv = 0; m_fn = 0; m_fc = 0; m_ovr = 0; m_hc = 0;
        end else if (start) begin
            for (int i = 0; i < NC; i++) begin m_n[i] = lo_of(i); m_x[i] = 0; end
            m_st = M_RUN; m_fv = 0; m_ovr = 0;
        end else begin
            bit all_x, cap;
            int hits, first;
            all_x = 1; cap = 0; hits = 0; first = -1;
            for (int i = 0; i < NC; i++) if (!m_x[i]) all_x = 0;
            if (m_st == M_RUN)
                for (int i = 0; i < NC; i++)
                    if (core_found[i]) begin hits++; if (first < 0) first = i; end
            if (hits > 0) begin
                if (!m_fv) begin
                    m_fn = m_n[first]; m_fc = first; cap = 1;
                    if (hits > 1) m_ovr = 1;
                end else begin
                    m_ovr = 1;
                end
            end
            if (cap) m_fv = 1;
            else if (found_ack) m_fv = 0;
            if (m_st == M_RUN)
                for (int i = 0; i < NC; i++)
                    if (cycle[i*CW +: CW] == CW'(LAST) && !m_x[i]) begin
                        m_hc++;
                        if (m_n[i] == hi_of(i)) m_x[i] = 1;
                        else m_n[i]++;
                    end
            if (abort) m_st = M_IDLE;
            else if (m_st == M_RUN && cap) m_st = M_HOLD;
            else if (m_st == M_RUN && all_x) m_st = M_DONE;
            else if (m_st == M_HOLD && found_ack) m_st = M_IDLE;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [NC-1:0] mx;
            for (int i = 0; i < NC; i++) begin
                mx[i] = m_x[i];
                chk($sformatf("nonce%0d", i), 64'(nonce[i*W +: W]), 64'(m_n[i]));
            end
            chk("exhausted", 64'(exhausted), 64'(mx));
            chk("busy", 64'(busy), 64'(m_st == M_RUN));
            chk("done", 64'(done), 64'(m_st == M_DONE));
            chk("found_valid", 64'(found_valid), 64'(m_fv));
            chk("found_nonce", 64'(found_nonce), 64'(m_fn));
            chk("found_core", 64'(found_core), 64'(m_fc));
            chk("found_ovr", 64'(found_ovr), 64'(m_ovr));
`ifdef NONCE_STATS_EN
            chk("hash_count", hash_count, m_hc);
`else
            chk("hash_count", hash_count, 64'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_all(input logic [CW-1:0] v);
        for (int i = 0; i < NC; i++) cycle[i*CW +: CW] = v;
    endtask

    initial begin
        logic [63:0] hc0;
        logic [63:0] hc_exp;

        // 1: reset and idle
        n_rst = 1'b0;
        step(2);
        chk_on = 1'b1;
        chk("rst_nonce", 64'(nonce), 64'h00000000_C0804000);
        n_rst = 1'b1;
        step(1);
        chk("idle_nonce", 64'(nonce), 64'h00000000_C0804000);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_fv", 64'(found_valid), 64'd0);

        // 5: three-lane split
        chk("n3_rst", 64'(nonce3), 64'(24'hAA5500));
        start3 = 1'b1; step(1); start3 = 1'b0;
        for (int i = 0; i < 3; i++) cycle3[i*CW +: CW] = CW'(LAST);
        step(85);
        chk("n3_end", 64'(nonce3), 64'(24'hFFA954));
        chk("n3_exh85", 64'(exhausted3), 64'd3);
        step(1);
        chk("n3_exh86", 64'(exhausted3), 64'd7);
        cycle3 = '0;

        // 2: advance lane 1 only
        start = 1'b1; step(1); start = 1'b0;
        chk("run_busy", 64'(busy), 64'd1);
        cycle[1*CW +: CW] = CW'(LAST);
        step(3);
        cycle = '0;
        chk("lane1_67", 64'(nonce), 64'h00000000_C0804300);

        // 3: exhaust every lane
        set_all(CW'(LAST));
        step(63);
        chk("lane3_255", 64'(nonce[3*W +: W]), 64'd255);
        chk("exh_partial", 64'(exhausted), 64'h2);
        step(1);
        chk("exh_all", 64'(exhausted), 64'hF);
        chk("lane3_hold", 64'(nonce[3*W +: W]), 64'd255);
        chk("still_busy", 64'(busy), 64'd1);
        set_all('0);
        step(1);
        chk("done_set", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);

        // 4: simultaneous finds, lowest lane wins
        start = 1'b1; step(1); start = 1'b0;
        cycle[0 +: CW] = CW'(LAST); cycle[2*CW +: CW] = CW'(LAST);
        step(2);
        cycle[2*CW +: CW] = '0;
        step(3);
        chk("pre_find", 64'(nonce), 64'h00000000_C0824005);
        core_found = 4'b0101;
        step(1);
        core_found = '0; cycle = '0;
        chk("find_fv", 64'(found_valid), 64'd1);
        chk("find_nonce", 64'(found_nonce), 64'd5);
        chk("find_core", 64'(found_core), 64'd0);
        chk("find_ovr", 64'(found_ovr), 64'd1);
        chk("hold_busy", 64'(busy), 64'd0);
        set_all(CW'(LAST));
        step(2);
        set_all('0);
        chk("hold_frozen", 64'(nonce), 64'h00000000_C0824006);
        found_ack = 1'b1; step(1); found_ack = 1'b0;
        chk("ack_fv", 64'(found_valid), 64'd0);
        chk("ack_done", 64'(done), 64'd0);
        chk("ack_busy", 64'(busy), 64'd0);

        // 6: stats over ten full strobes, then reset mid-run
        start = 1'b1; step(1); start = 1'b0;
        hc0 = hash_count;
        set_all(CW'(LAST));
        step(10);
        set_all('0);
`ifdef NONCE_STATS_EN
        hc_exp = hc0 + 64'd40;
`else
        hc_exp = 64'd0;
`endif
        chk("hash40", hash_count, hc_exp);
        set_all(CW'(LAST));
        n_rst = 1'b0; step(1);
        chk("mid_rst_nonce", 64'(nonce), 64'h00000000_C0804000);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hc", hash_count, 64'd0);
        chk("mid_rst_exh", 64'(exhausted), 64'd0);
        n_rst = 1'b1;
        set_all('0);

        // randomized blocks: even blocks suppress finds so lanes reach DONE
        for (int b = 0; b < 30; b++) begin
            start = 1'b1; step(1); start = 1'b0;
            for (int c = 0; c < 100; c++) begin
                for (int i = 0; i < NC; i++) begin
                    cycle[i*CW +: CW] = ($urandom_range(3) != 0) ? CW'(LAST) : CW'($urandom_range(62));
                    core_found[i] = (b % 2 == 1) && ($urandom_range(19) == 0);
                end
                abort     = ($urandom_range(199) == 0);
                found_ack = ($urandom_range(2) == 0);
                start     = ($urandom_range(299) == 0);
                n_rst     = ($urandom_range(999) != 0);
                step(1);
            end
            start = 1'b0; abort = 1'b0; found_ack = 1'b0; n_rst = 1'b1;
            core_found = '0; cycle = '0;
        end

        step(1);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
